// File: rtl/mem_arbiter.sv
// Two-port (A instruction, B data) arbiter onto a single-word memory port; optional round-robin via MEM_ARB_ROUND_ROBIN_EN.
// Latency: gnt with the request cycle, strobes one cycle later, valid/rdata two cycles later; one access per 3 cycles; busy ports are ignored, not queued.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic              a_byte,
    input  logic              b_byte,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_valid,
    output logic              b_valid,
    output logic              a_err,
    output logic              b_err,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] DEPTH_U = DEPTH;

    state_t            state;
    logic              cur_b;
    logic              cur_we;
    logic              cur_byte;
    logic              cur_ok;
    logic              win_b;
    logic              grant;
    logic              sel_we;
    logic              sel_byte;
    logic              sel_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_result;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // prio_b set means B is preferred on the next tie (A was granted last).
    logic prio_b;
    assign win_b = b_req && (!a_req || prio_b);
`else
    assign win_b = b_req;
`endif

    // gnt is decoded in the request cycle so the fields are captured on that same edge.
    assign grant     = (state == IDLE) && (a_req || b_req) && !reset;
    assign a_gnt     = grant && !win_b;
    assign b_gnt     = grant && win_b;
    assign busy      = (state != IDLE);

    assign sel_we    = win_b ? b_we    : a_we;
    assign sel_byte  = win_b ? b_byte  : a_byte;
    assign sel_addr  = win_b ? b_addr  : a_addr;
    assign sel_wdata = win_b ? b_wdata : a_wdata;
    assign sel_ok    = 32'(sel_addr) < DEPTH_U;

    assign rd_result = (!cur_ok || cur_we) ? '0 :
                       cur_byte ? {{(DATA_W-8){1'b0}}, mem_rdata[7:0]} : mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_b     <= 1'b0;
            cur_we    <= 1'b0;
            cur_byte  <= 1'b0;
            cur_ok    <= 1'b0;
            a_valid   <= 1'b0;
            b_valid   <= 1'b0;
            a_err     <= 1'b0;
            b_err     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio_b    <= 1'b0;
`endif
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_byte  <= 1'b0;
            a_valid   <= 1'b0;
            b_valid   <= 1'b0;
            a_err     <= 1'b0;
            b_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        cur_b     <= win_b;
                        cur_we    <= sel_we;
                        cur_byte  <= sel_byte;
                        cur_ok    <= sel_ok;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        // Out-of-range accesses never strobe the memory.
                        mem_read  <= sel_ok && !sel_we;
                        mem_write <= sel_ok && sel_we;
                        mem_byte  <= sel_ok && sel_byte;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        prio_b    <= !win_b;
`endif
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cur_b) begin
                        b_rdata <= rd_result;
                        b_valid <= 1'b1;
                        b_err   <= !cur_ok;
                    end else begin
                        a_rdata <= rd_result;
                        a_valid <= 1'b1;
                        a_err   <= !cur_ok;
                    end
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter DEPTH, default 32, number of implemented memory words; higher addresses are out of range.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 a_req, b_req  input  1 each  access request from port A (instruction side) and port B (data side).
REQ-007 a_we, b_we  input  1 each  1 = write, 0 = read.
REQ-008 a_byte, b_byte  input  1 each  byte operation (low byte only).
REQ-009 a_addr, b_addr  input  ADDR_W each  word address.
REQ-010 a_wdata, b_wdata  input  DATA_W each  write data.
REQ-011 a_gnt, b_gnt  output  1 each  one-cycle pulse: request accepted, fields captured.
REQ-012 a_valid, b_valid  output  1 each  one-cycle pulse: access complete.
REQ-013 a_err, b_err  output  1 each  qualifies valid: address out of range.
REQ-014 a_rdata, b_rdata  output  DATA_W each  read result, meaningful while valid.
REQ-015 mem_read, mem_write, mem_byte  output  1 each  memory strobes.
REQ-016 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  memory address / write data.
REQ-017 mem_rdata  input  DATA_W  combinational memory read data.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-020 IDLE: on any req, select winner, pulse its gnt, capture we/byte/addr/wdata, go to ACCESS; no req -> stay IDLE.
REQ-021 ACCESS lasts exactly one cycle: mem_addr/mem_wdata/mem_byte driven from captured fields; mem_read = !we, mem_write = we, both registered.
REQ-022 Strobes never high outside ACCESS; mem_read and mem_write never high together.
REQ-023 In ACCESS, read data sampled from mem_rdata into the winner's rdata register; RESP follows.
REQ-024 RESP: winner's valid pulses one cycle; return to IDLE next edge; loser's valid/gnt stay 0.
REQ-025 Latency: req high at edge N -> gnt in cycle N, strobes in N+1, valid/rdata in N+2; back-to-back throughput one access per 3 cycles.
REQ-026 Requester may drop req after gnt; req held high after valid is a new request.
REQ-027 Byte read: rdata = {24'b0, mem_rdata[7:0]}; byte write passes wdata unchanged with mem_byte = 1.
REQ-028 Write completion: valid pulses, rdata = 0.
REQ-029 addr >= DEPTH: no strobes in ACCESS, valid with err = 1, rdata = 0; memory untouched.
REQ-030 rdata holds last value until the port's next completion.
REQ-031 Requests arriving while busy are ignored until IDLE; no queuing.

Reset
REQ-032 reset high at an edge: state -> IDLE; gnt, valid, err, strobes, busy -> 0; rdata, mem_addr, mem_wdata -> 0; priority pointer -> A.
REQ-033 Reset during ACCESS or RESP drops the transaction; no valid is ever issued for it.
REQ-034 The first edge after reset deasserts may grant a request.

Configuration
REQ-035 Macro MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests go to the port not granted last; pointer updates on every grant, starts at A.
REQ-036 Macro undefined: fixed priority, B always wins ties; A served only when B idle; no pointer register.

Verification
REQ-037 A read addr 5 (mem[5]=32'hDEADBEEF) -> a_gnt cycle N, mem_read cycle N+1, a_valid with a_rdata=32'hDEADBEEF cycle N+2.
REQ-038 B byte write addr 3, wdata 32'h000000AB -> one-cycle mem_write, mem_byte=1; later B word read addr 3 returns low byte 8'hAB.
REQ-039 A and B both req continuously, RR_EN defined -> grants A,B,A,B; undefined -> B,B,B, A never granted.
REQ-040 A read addr 8'd40 -> no strobes, a_valid=1, a_err=1, a_rdata=0.
REQ-041 reset asserted in ACCESS cycle of a write -> strobes 0 next cycle, no valid, busy=0; fresh request then completes normally.
